// File: rtl/vm3_vic_pkg.sv
// Shared constants for the VM3 vectored interrupt controller: FSM encodings,
// pass vector and the vector-field formatting helper.
package vm3_vic_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SEL  = 2'd1;
    localparam logic [1:0] ST_ACK  = 2'd2;
    localparam logic [1:0] ST_WAIT = 2'd3;

    localparam logic [15:0] VIC_PASS_VEC = 16'o000274;

    // A source supplies an 8-bit field; the CPU sees it as a word-aligned vector.
    function automatic logic [15:0] vic_vector(input logic [7:0] f);
        return {7'o000, f, 1'b0};
    endfunction

endpackage

// File: rtl/vm3_vic_prio.sv
// Fixed-priority encoder: reports the lowest set index of pend and whether any bit is set.
module vm3_vic_prio #(
    parameter int N  = 8,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  pend,
    output logic [IW-1:0] idx,
    output logic          valid
);

    always_comb begin
        idx   = '0;
        valid = |pend;
        // Scanning downwards lets the lowest set index win.
        for (int unsigned i = N; i > 0; i--) begin
            if (pend[i-1]) idx = IW'(i - 1);
        end
    end

endmodule

// File: rtl/vm3_vic.sv
// VM3 vectored interrupt controller: masks level requests, serves the vector fetch
// for the highest-priority pending source and exposes mask/pending over Wishbone.
module vm3_vic
    import vm3_vic_pkg::*;
#(
    parameter int          N_IRQ     = 8,
    parameter logic [15:0] MASK_INIT = 16'hFFFF,
    parameter logic [15:0] PASS_VEC  = VIC_PASS_VEC
) (
    input  logic               vm_clk_p,
    input  logic               vm_init,
    input  logic [N_IRQ-1:0]   irq_req,
    input  logic [8*N_IRQ-1:0] irq_vec,
    output logic [N_IRQ-1:0]   irq_ack,
    output logic               vm_virq,
    input  logic               wbi_stb_i,
    output logic [15:0]        wbi_dat_o,
    output logic               wbi_ack_o,
    input  logic               wbs_adr_i,
    input  logic [15:0]        wbs_dat_i,
    output logic [15:0]        wbs_dat_o,
    input  logic               wbs_cyc_i,
    input  logic               wbs_stb_i,
    input  logic               wbs_we_i,
    output logic               wbs_ack_o
);

    localparam int IW = (N_IRQ > 1) ? $clog2(N_IRQ) : 1;

    logic [1:0]       state;
    logic [N_IRQ-1:0] mask;
    logic [N_IRQ-1:0] pend;
    logic [IW-1:0]    win_idx;
    logic             win_valid;
    logic [15:0]      sel_vec;
    logic [N_IRQ-1:0] sel_onehot;
    logic             rd_lock;
    logic             wr_lock;

    assign pend = irq_req & mask;

    vm3_vic_prio #(
        .N  (N_IRQ),
        .IW (IW)
    ) u_prio (
        .pend  (pend),
        .idx   (win_idx),
        .valid (win_valid)
    );

    always_comb begin
        sel_onehot = '0;
        sel_vec    = PASS_VEC;
        if (win_valid) begin
            sel_onehot[win_idx] = 1'b1;
            sel_vec             = vic_vector(irq_vec[{win_idx, 3'b000} +: 8]);
        end
    end

    always_ff @(posedge vm_clk_p or posedge vm_init) begin
        if (vm_init) begin
            state     <= ST_IDLE;
            wbi_ack_o <= 1'b0;
            wbi_dat_o <= '0;
            irq_ack   <= '0;
            vm_virq   <= 1'b0;
        end else begin
            wbi_ack_o <= 1'b0;
            irq_ack   <= '0;
            // The acked source needs a cycle to drop its level before we re-request.
            vm_virq   <= (state == ST_IDLE) && (|pend) && !(|irq_ack);
            case (state)
                ST_IDLE: if (wbi_stb_i) state <= ST_SEL;
                ST_SEL: begin
                    if (!wbi_stb_i) begin
                        state <= ST_IDLE;
                    end else begin
                        state     <= ST_ACK;
                        wbi_ack_o <= 1'b1;
                        wbi_dat_o <= sel_vec;
                        irq_ack   <= sel_onehot;
                    end
                end
                ST_ACK:  state <= ST_WAIT;
                ST_WAIT: if (!wbi_stb_i) state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Lock flags make a strobe held across several cycles produce a single ack.
    always_ff @(posedge vm_clk_p or posedge vm_init) begin
        if (vm_init) begin
            mask      <= MASK_INIT[N_IRQ-1:0];
            wbs_ack_o <= 1'b0;
            wbs_dat_o <= '0;
            rd_lock   <= 1'b0;
            wr_lock   <= 1'b0;
        end else begin
            wbs_ack_o <= 1'b0;
            if (!wbs_cyc_i) begin
                rd_lock <= 1'b0;
                wr_lock <= 1'b0;
            end else if (wbs_stb_i) begin
                if (wbs_we_i && !wr_lock) begin
                    wr_lock   <= 1'b1;
                    wbs_ack_o <= 1'b1;
                    if (!wbs_adr_i) mask <= wbs_dat_i[N_IRQ-1:0];
                end else if (!wbs_we_i && !rd_lock) begin
                    rd_lock   <= 1'b1;
                    wbs_ack_o <= 1'b1;
                    wbs_dat_o <= wbs_adr_i ? 16'(pend) : 16'(mask);
                end
            end
        end
    end

endmodule

// File: tb/tb_vm3_vic.sv
// Self-checking bench for vm3_vic: directed scenarios plus randomized fetches
// against a transaction-level model of mask, priority and vector delivery.
module tb_vm3_vic;

    localparam int          N        = 8;
    localparam logic [15:0] PASS_VEC = 16'o000274;

    logic          clk = 1'b0;
    logic          vm_init;
    logic [N-1:0]  irq_req;
    logic [8*N-1:0] irq_vec;
    logic [N-1:0]  irq_ack;
    logic          vm_virq;
    logic          wbi_stb_i;
    logic [15:0]   wbi_dat_o;
    logic          wbi_ack_o;
    logic          wbs_adr_i;
    logic [15:0]   wbs_dat_i;
    logic [15:0]   wbs_dat_o;
    logic          wbs_cyc_i;
    logic          wbs_stb_i;
    logic          wbs_we_i;
    logic          wbs_ack_o;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    logic [7:0] mask_m;
    logic [7:0] f [N];

    always #5 clk = ~clk;

    vm3_vic #(
        .N_IRQ     (N),
        .MASK_INIT (16'hFFFF),
        .PASS_VEC  (PASS_VEC)
    ) dut (
        .vm_clk_p  (clk),
        .vm_init   (vm_init),
        .irq_req   (irq_req),
        .irq_vec   (irq_vec),
        .irq_ack   (irq_ack),
        .vm_virq   (vm_virq),
        .wbi_stb_i (wbi_stb_i),
        .wbi_dat_o (wbi_dat_o),
        .wbi_ack_o (wbi_ack_o),
        .wbs_adr_i (wbs_adr_i),
        .wbs_dat_i (wbs_dat_i),
        .wbs_dat_o (wbs_dat_o),
        .wbs_cyc_i (wbs_cyc_i),
        .wbs_stb_i (wbs_stb_i),
        .wbs_we_i  (wbs_we_i),
        .wbs_ack_o (wbs_ack_o)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic load_vec;
        for (int i = 0; i < N; i++) irq_vec[i*8 +: 8] = f[i];
    endtask

    task automatic wbs_write(input logic adr, input logic [15:0] data);
        wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = 1'b1;
        wbs_adr_i = adr;  wbs_dat_i = data;
        tick;
        check("wbs_wr_ack", 32'(wbs_ack_o), 32'd1);
        wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0;
        tick;
        check("wbs_wr_ack_drop", 32'(wbs_ack_o), 32'd0);
        if (!adr) mask_m = data[7:0];
    endtask

    task automatic wbs_read(input logic adr, output logic [15:0] d);
        wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = 1'b0; wbs_adr_i = adr;
        tick;
        check("wbs_rd_ack", 32'(wbs_ack_o), 32'd1);
        d = wbs_dat_o;
        wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
        tick;
    endtask

    // Model: winner is the least significant pending bit; vector is twice its field.
    task automatic fetch(input string tag);
        logic [7:0]  p, low;
        logic [15:0] ev;
        p   = irq_req & mask_m;
        low = p & (~p + 8'd1);
        ev  = PASS_VEC;
        for (int i = 0; i < N; i++)
            if (low[i]) ev = 16'(f[i]) * 16'd2;
        wbi_stb_i = 1'b1;
        tick;
        check({tag, "_ack_early"}, 32'(wbi_ack_o), 32'd0);
        tick;
        check({tag, "_ack"}, 32'(wbi_ack_o), 32'd1);
        check({tag, "_dat"}, 32'(wbi_dat_o), 32'(ev));
        check({tag, "_irq_ack"}, 32'(irq_ack), 32'(low));
        irq_req   = irq_req & ~low;
        wbi_stb_i = 1'b0;
        tick;
        check({tag, "_ack_drop"}, 32'(wbi_ack_o), 32'd0);
        check({tag, "_irq_ack_drop"}, 32'(irq_ack), 32'd0);
        check({tag, "_dat_hold"}, 32'(wbi_dat_o), 32'(ev));
        tick;
        tick;
    endtask

    initial begin
        logic [15:0] d;
        int unsigned acks;

        vm_init = 1'b1; irq_req = '0; irq_vec = '0; wbi_stb_i = 1'b0;
        wbs_adr_i = 1'b0; wbs_dat_i = '0; wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0;
        mask_m = 8'hFF;
        for (int i = 0; i < N; i++) f[i] = 8'(i + 1);
        load_vec;
        tick; tick;
        check("rst_virq", 32'(vm_virq), 32'd0);
        check("rst_wbi_ack", 32'(wbi_ack_o), 32'd0);
        check("rst_wbi_dat", 32'(wbi_dat_o), 32'd0);
        check("rst_wbs_dat", 32'(wbs_dat_o), 32'd0);
        vm_init = 1'b0;
        tick;

        // Reset during ACK, with a non-default mask to show it is restored.
        wbs_write(1'b0, 16'h000F);
        irq_req = 8'h01;
        tick; tick;
        wbi_stb_i = 1'b1;
        tick; tick;
        check("pre_rst_ack", 32'(wbi_ack_o), 32'd1);
        vm_init = 1'b1;
        #1;
        check("rst_mid_ack", {13'd0, wbi_ack_o, vm_virq, wbs_ack_o, irq_ack, wbi_dat_o}, 32'd0);
        wbi_stb_i = 1'b0; irq_req = '0;
        tick;
        vm_init = 1'b0; mask_m = 8'hFF;
        tick;
        wbs_read(1'b0, d);
        check("rst_mask", 32'(d), 32'h00FF);

        // Two-source fetch sequence in priority order.
        f[2] = 8'o30; f[5] = 8'o40; load_vec;
        irq_req = 8'h24;
        tick; tick;
        check("virq_two_src", 32'(vm_virq), 32'd1);
        fetch("fetch_hi");
        fetch("fetch_lo");

        // Masked source keeps virq low until unmasked.
        wbs_write(1'b0, 16'h00FB);
        irq_req = 8'h04;
        tick; tick;
        check("masked_virq", 32'(vm_virq), 32'd0);
        wbs_read(1'b1, d);
        check("masked_pend", 32'(d), 32'd0);
        wbs_write(1'b0, 16'h00FF);
        check("unmask_virq", 32'(vm_virq), 32'd1);
        fetch("fetch_unmask");

        // Source withdrawn before the fetch gets the pass vector.
        irq_req = 8'h08;
        tick; tick;
        irq_req = 8'h00;
        tick;
        fetch("fetch_pass");

        // Strobe abort in SEL.
        irq_req = 8'h02;
        tick; tick;
        wbi_stb_i = 1'b1;
        tick;
        wbi_stb_i = 1'b0;
        tick;
        check("abort_ack", 32'(wbi_ack_o), 32'd0);
        check("abort_irq_ack", 32'(irq_ack), 32'd0);
        check("abort_virq_low", 32'(vm_virq), 32'd0);
        tick;
        check("abort_ack2", 32'(wbi_ack_o), 32'd0);
        check("abort_virq_back", 32'(vm_virq), 32'd1);
        fetch("fetch_after_abort");

        // Held slave strobe acks once; upper mask bits and pending writes are ignored.
        wbs_write(1'b0, 16'hFF3C);
        wbs_write(1'b1, 16'h0000);
        wbs_read(1'b0, d);
        check("mask_upper_ignored", 32'(d), 32'h003C);
        irq_req = 8'hA5;
        wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = 1'b0; wbs_adr_i = 1'b1;
        acks = 0; d = '0;
        for (int i = 0; i < 4; i++) begin
            tick;
            if (wbs_ack_o) begin
                acks++;
                d = wbs_dat_o;
            end
        end
        wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
        tick;
        check("held_stb_acks", acks, 32'd1);
        check("held_pend", 32'(d), 32'(8'hA5 & 8'h3C));
        irq_req = '0;
        tick; tick;

        // Randomized mask/request/vector mixes.
        for (int it = 0; it < 30; it++) begin
            for (int i = 0; i < N; i++) f[i] = 8'($urandom);
            load_vec;
            if ($urandom_range(0, 2) == 0) wbs_write(1'b0, 16'($urandom));
            irq_req = 8'($urandom);
            tick; tick;
            check("rnd_virq", 32'(vm_virq), 32'(|(irq_req & mask_m)));
            wbs_read(1'b1, d);
            check("rnd_pend", 32'(d), 32'(irq_req & mask_m));
            fetch("rnd_fetch");
            if ($urandom_range(0, 1) == 0) fetch("rnd_fetch2");
            irq_req = '0;
            tick;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
